// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single regfile write port: ALU-priority grant with an LSU
// starvation guard, one registered output stage and a pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc_valid,
    input  logic [4:0]      alloc_addr,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_addr,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data,
    input  logic [4:0]      chk_rs1_addr,
    input  logic [4:0]      chk_rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0]      starve_cnt_r;
    logic [31:0]     busy_r;
    logic [31:0]     busy_nxt_s;
    logic            lsu_force_s;
    logic            alu_grant_s;
    logic            lsu_grant_s;
    logic            accept_s;
    logic [4:0]      win_addr_s;
    logic [XLEN-1:0] win_data_s;

    // A source is busy if a write is pending or sits in the output stage this cycle.
    function automatic logic src_busy(
        input logic [31:0] busy,
        input logic [4:0]  src,
        input logic        we,
        input logic [4:0]  wr_addr
    );
        if (src == 5'd0) begin
            return 1'b0;
        end else begin
            return busy[src] | (we & (wr_addr == src));
        end
    endfunction

    // Grant selection: forced LSU, then ALU, then LSU; nothing is granted while in reset.
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        lsu_force_s = lsu_valid && (starve_cnt_r == LIMIT_C);
        if (!rst_n) begin
            alu_grant_s = 1'b0;
        end else if (lsu_force_s) begin
            lsu_grant_s = 1'b1;
        end else if (alu_valid) begin
            alu_grant_s = 1'b1;
        end else if (lsu_valid) begin
            lsu_grant_s = 1'b1;
        end else begin
            lsu_grant_s = 1'b0;
        end
        accept_s   = alu_grant_s | lsu_grant_s;
        win_addr_s = lsu_grant_s ? lsu_addr : alu_addr;
        win_data_s = lsu_grant_s ? lsu_data : alu_data;
    end

    assign alu_ready = alu_grant_s;
    assign lsu_ready = lsu_grant_s;

    // Scoreboard next state: flush wipes everything, otherwise an allocation beats a retire.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = 32'h0;
        end else begin
            if (accept_s) begin
                busy_nxt_s[win_addr_s] = 1'b0;
            end else begin
                busy_nxt_s[0] = 1'b0;
            end
            if (alloc_valid && (alloc_addr != 5'd0)) begin
                busy_nxt_s[alloc_addr] = 1'b1;
            end else begin
                busy_nxt_s[0] = 1'b0;
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 32'h0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Consecutive-loss counter, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
        end else if (flush || !lsu_valid || lsu_grant_s) begin
            starve_cnt_r <= 4'd0;
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Output stage: x0 writes are accepted but never reach the regfile enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= 5'd0;
            rf_rd_data <= '0;
        end else if (accept_s) begin
            rf_we      <= (win_addr_s != 5'd0);
            rf_rd_addr <= win_addr_s;
            rf_rd_data <= win_data_s;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    assign rs1_busy = rst_n & src_busy(busy_r, chk_rs1_addr, rf_we, rf_rd_addr);
    assign rs2_busy = rst_n & src_busy(busy_r, chk_rs2_addr, rf_we, rf_rd_addr);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected regfile writes are queued when a grant is
// expected and compared one cycle later when the output stage presents them.
module tb_rf_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [4:0]  chk_rs1_addr;
    logic [4:0]  chk_rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;

    int          errors = 0;
    int          checks = 0;
    wr_t         exp_q[$];
    logic [31:0] rf_model [32] = '{default: 32'h0};

    rf_wb_arbiter #(.STARVE_LIMIT(3), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .chk_rs1_addr(chk_rs1_addr), .chk_rs2_addr(chk_rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    // Behavioural regfile fed by the arbiter's write port.
    always @(posedge clk) begin
        if (rf_we) rf_model[rf_rd_addr] <= rf_rd_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check grants/busy mid-cycle, queue the expected write, then check the output stage.
    task automatic cycle(input string tag, input logic ea, input logic el,
                         input logic eb1, input logic eb2);
        wr_t e;
        @(negedge clk);
        chk({tag, ".alu_ready"}, {31'h0, alu_ready}, {31'h0, ea});
        chk({tag, ".lsu_ready"}, {31'h0, lsu_ready}, {31'h0, el});
        chk({tag, ".rs1_busy"},  {31'h0, rs1_busy},  {31'h0, eb1});
        chk({tag, ".rs2_busy"},  {31'h0, rs2_busy},  {31'h0, eb2});
        if (ea) exp_q.push_back('{we: (alu_addr != 5'd0), addr: alu_addr, data: alu_data});
        else if (el) exp_q.push_back('{we: (lsu_addr != 5'd0), addr: lsu_addr, data: lsu_data});
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".rf_we"},   {31'h0, rf_we}, {31'h0, e.we});
            chk({tag, ".rf_addr"}, {27'h0, rf_rd_addr}, {27'h0, e.addr});
            chk({tag, ".rf_data"}, rf_rd_data, e.data);
        end else begin
            chk({tag, ".rf_we_idle"}, {31'h0, rf_we}, 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_addr = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h2;
        chk_rs1_addr = 5'd0; chk_rs2_addr = 5'd0;
        #2;
        chk("rst.rf_we",     {31'h0, rf_we}, 32'h0);
        chk("rst.rf_addr",   {27'h0, rf_rd_addr}, 32'h0);
        chk("rst.rf_data",   rf_rd_data, 32'h0);
        chk("rst.alu_ready", {31'h0, alu_ready}, 32'h0);
        chk("rst.lsu_ready", {31'h0, lsu_ready}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;

        // ALU alone is granted at once and written the next cycle
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h12345678;
        cycle("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        alu_valid = 1'b0;
        cycle("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1.addr_hold", {27'h0, rf_rd_addr}, 32'd1);
        chk("t1.rf_x1", rf_model[1], 32'h12345678);

        // Both requesting every cycle: every fourth grant is forced to the LSU
        lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h87654321;
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = 32'(i + 100);
            cycle($sformatf("t2_%0d", i), (i % 4) != 3, (i % 4) == 3, 1'b0, 1'b0);
            if ((i % 4) == 3) begin
                lsu_addr = 5'd4; lsu_data = 32'hCAFE0004;
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        cycle("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2.rf_x2", rf_model[2], 32'h87654321);

        // x0 write is accepted but never enables the regfile
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFFFFFF;
        cycle("t3", 1'b0, 1'b1, 1'b0, 1'b0);
        lsu_valid = 1'b0;
        cycle("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3.rf_x0", rf_model[0], 32'h0);

        // Scoreboard set, retire, and the one-cycle output-stage window
        chk_rs1_addr = 5'd5;
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        cycle("t4_alloc", 1'b0, 1'b0, 1'b0, 1'b0);
        alloc_valid = 1'b0;
        cycle("t4_pend", 1'b0, 1'b0, 1'b1, 1'b0);
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h55;
        cycle("t4_acc", 1'b1, 1'b0, 1'b1, 1'b0);
        alu_valid = 1'b0;
        cycle("t4_wb", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("t4_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Set beats clear on the same address; flush clears busy and the starve counter
        chk_rs2_addr = 5'd7;
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        cycle("t5_alloc", 1'b0, 1'b0, 1'b0, 1'b0);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
        cycle("t5_setclr", 1'b1, 1'b0, 1'b0, 1'b1);
        alloc_valid = 1'b0; alu_addr = 5'd8; alu_data = 32'h88;
        cycle("t5_acc8", 1'b1, 1'b0, 1'b0, 1'b1);
        flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd7;
        alu_addr = 5'd6; alu_data = 32'h66;
        cycle("t5_flush", 1'b1, 1'b0, 1'b0, 1'b1);
        flush = 1'b0; alloc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_addr = 5'(16 + i); alu_data = 32'(i + 200);
            cycle($sformatf("t5_post%0d", i), i != 3, i == 3, 1'b0, 1'b0);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        cycle("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during an output-stage write of x3
        chk_rs1_addr = 5'd3;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33333333;
        cycle("t6_acc", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6.rf_we",     {31'h0, rf_we}, 32'h0);
        chk("t6.rf_addr",   {27'h0, rf_rd_addr}, 32'h0);
        chk("t6.rf_data",   rf_rd_data, 32'h0);
        chk("t6.alu_ready", {31'h0, alu_ready}, 32'h0);
        chk("t6.rs1_busy",  {31'h0, rs1_busy}, 32'h0);
        @(posedge clk); #1;
        chk("t6.rf_x3", rf_model[3], 32'h0);
        alu_valid = 1'b0; rst_n = 1'b1;
        cycle("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
